// File: rtl/liang_pkg.sv
// rtl/liang_pkg.sv - shared fetch/decode types and the fetch-stage reset PC
//
// Types:
//   pc_t        32-bit program counter
//   inst_t      32-bit instruction word
//   ifToId_t    {pc, inst} pair handed from IF to ID
//   fq_entry_t  one fetch-queue slot, same layout as ifToId_t
// Constants:
//   IF_RESET_PC PC loaded into the fetch stage on reset
package liang_pkg;

    typedef logic [31:0] pc_t;
    typedef logic [31:0] inst_t;

    typedef struct packed {
        pc_t   pc;
        inst_t inst;
    } ifToId_t;

    typedef ifToId_t fq_entry_t;

    localparam pc_t IF_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_fetch_queue.sv
// rtl/ifu_fetch_queue.sv - synchronous FIFO used for the fetch queue and the PC tracker
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   clear_i        drop all entries (wins over push/pop)
//   push_i/push_data_i  write one entry at the tail
//   pop_i          retire the head entry
//   head_o         current head entry (undefined content when empty)
//   count_o        number of valid entries
//   empty_o        no valid entries
module ifu_fetch_queue
    import liang_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = $bits(fq_entry_t),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;

    // DEPTH need not be a power of two (the PC tracker uses MAX_OUTSTANDING),
    // so pointers wrap explicitly instead of relying on overflow.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full    = (int'(count_q) == DEPTH);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full queue is only legal when the head leaves in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !clear_i && push_i && !pop_i) begin
            assert (!full);
        end
    end

endmodule

// File: rtl/pipe_ifu_fq.sv
// rtl/pipe_ifu_fq.sv - instruction fetch stage with pipelined memory requests and a fetch queue
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   flush_i, flush_pc_i          redirect: drop queued/in-flight fetches, restart at flush_pc_i
//   imem_req_valid_o/ready_i     fetch request handshake, address on imem_req_addr_o
//   imem_resp_valid_i/inst_i     in-order fetch responses, always accepted
//   ifToId_o, if_valid_o         fetch-queue head {pc, inst} offered to ID
//   id_ready_i                   ID consumes the head
module pipe_ifu_fq
    import liang_pkg::*;
#(
    parameter int  FQ_DEPTH        = 4,
    parameter int  MAX_OUTSTANDING = 2,
    parameter pc_t RESET_PC        = IF_RESET_PC
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    flush_i,
    input  pc_t     flush_pc_i,
    output logic    imem_req_valid_o,
    input  logic    imem_req_ready_i,
    output pc_t     imem_req_addr_o,
    input  logic    imem_resp_valid_i,
    input  inst_t   imem_resp_inst_i,
    output ifToId_t ifToId_o,
    output logic    if_valid_o,
    input  logic    id_ready_i
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW = $clog2(FQ_DEPTH + 1);

    pc_t           pc_q, pc_d;
    logic [OW-1:0] drop_cnt_q, drop_cnt_d;
    logic [OW-1:0] outstanding;
    logic [FW-1:0] fq_count;
    logic          fq_empty, trk_empty;
    fq_entry_t     fq_head, fq_push_data;
    pc_t           trk_head;
    logic          credit_ok, req_fire, resp_drop, fq_push, fq_pop, trk_pop;

    // Every issued request reserves a queue slot up front, so a response can
    // always be pushed without backpressure. The tracker's occupancy is the
    // outstanding-request count.
    always_comb begin
        credit_ok        = (int'(fq_count) + int'(outstanding)) < FQ_DEPTH;
        imem_req_valid_o = !rst_i && !flush_i && credit_ok
                           && (int'(outstanding) < MAX_OUTSTANDING);
        req_fire         = imem_req_valid_o && imem_req_ready_i;
        if_valid_o       = !flush_i && !fq_empty;
        fq_pop           = if_valid_o && id_ready_i;
        resp_drop        = imem_resp_valid_i && (drop_cnt_q != '0);
        fq_push          = imem_resp_valid_i && !resp_drop && !flush_i;
        trk_pop          = imem_resp_valid_i && !trk_empty;
        fq_push_data     = '{pc: trk_head, inst: imem_resp_inst_i};

        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q - OW'(resp_drop);
        if (flush_i) begin
            pc_d = flush_pc_i;
            // No request fires during a flush; a response landing now is
            // already discarded, so only the ones still in flight need dropping.
            drop_cnt_d = outstanding - OW'(imem_resp_valid_i);
        end else if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    ifu_fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .WIDTH ($bits(fq_entry_t))
    ) u_fq (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (flush_i),
        .push_i      (fq_push),
        .push_data_i (fq_push_data),
        .pop_i       (fq_pop),
        .head_o      (fq_head),
        .count_o     (fq_count),
        .empty_o     (fq_empty)
    );

    // Dropped requests keep their tracker slot until their response arrives,
    // which keeps tracker order aligned with the response stream.
    ifu_fetch_queue #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH ($bits(pc_t))
    ) u_pc_track (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (1'b0),
        .push_i      (req_fire),
        .push_data_i (pc_q),
        .pop_i       (trk_pop),
        .head_o      (trk_head),
        .count_o     (outstanding),
        .empty_o     (trk_empty)
    );

    assign imem_req_addr_o = pc_q;
    assign ifToId_o        = fq_empty ? '0 : fq_head;

endmodule

// File: tb/tb_pipe_ifu_fq.sv
// tb/tb_pipe_ifu_fq.sv - directed self-checking bench for pipe_ifu_fq
module tb_pipe_ifu_fq;
    import liang_pkg::*;

    logic    clk_i = 1'b0;
    logic    rst_i = 1'b1;
    logic    flush_i = 1'b0;
    pc_t     flush_pc_i = '0;
    logic    imem_req_valid_o;
    logic    imem_req_ready_i = 1'b1;
    pc_t     imem_req_addr_o;
    logic    imem_resp_valid_i = 1'b0;
    inst_t   imem_resp_inst_i = '0;
    ifToId_t ifToId_o;
    logic    if_valid_o;
    logic    id_ready_i = 1'b0;

    pipe_ifu_fq dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .flush_i           (flush_i),
        .flush_pc_i        (flush_pc_i),
        .imem_req_valid_o  (imem_req_valid_o),
        .imem_req_ready_i  (imem_req_ready_i),
        .imem_req_addr_o   (imem_req_addr_o),
        .imem_resp_valid_i (imem_resp_valid_i),
        .imem_resp_inst_i  (imem_resp_inst_i),
        .ifToId_o          (ifToId_o),
        .if_valid_o        (if_valid_o),
        .id_ready_i        (id_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        pc_t addr;
        int  due;
    } pend_t;

    pend_t       pend_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_pop = 0;
    int          n_fire = 0;
    int          cyc = 0;
    int          delay = 1;
    int          p0, f0;
    pc_t         exp_pc = IF_RESET_PC;
    pc_t         exp_req_addr = IF_RESET_PC;
    logic        s_req_valid, s_if_valid;
    pc_t         s_addr;
    logic [63:0] s_data;

    function automatic inst_t inst_of(input pc_t pc);
        return {pc[15:0], pc[31:16]} ^ 32'hA5C3_0F17;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample at the falling edge, check requests and deliveries
    // against the reference stream, then advance the memory model past the rising edge.
    task automatic step();
        logic fire, pop;
        @(negedge clk_i);
        s_req_valid = imem_req_valid_o;
        s_addr      = imem_req_addr_o;
        s_if_valid  = if_valid_o;
        s_data      = ifToId_o;
        fire        = imem_req_valid_o && imem_req_ready_i;
        pop         = if_valid_o && id_ready_i;
        if (!rst_i) begin
            if (flush_i) begin
                chk("flush_no_req", imem_req_valid_o, 1'b0);
                chk("flush_no_valid", if_valid_o, 1'b0);
            end
            if (fire) begin
                chk("req_addr", s_addr, exp_req_addr);
                exp_req_addr += 32'd4;
                n_fire++;
            end
            if (pop) begin
                chk("deliver", s_data, {exp_pc, inst_of(exp_pc)});
                exp_pc += 32'd4;
                n_pop++;
            end
            if (flush_i) begin
                exp_req_addr = flush_pc_i;
                exp_pc       = flush_pc_i;
            end
        end
        @(posedge clk_i);
        #1;
        if (rst_i) begin
            pend_q.delete();
            exp_pc       = IF_RESET_PC;
            exp_req_addr = IF_RESET_PC;
        end else if (fire) begin
            pend_q.push_back('{addr: s_addr, due: cyc + delay});
        end
        cyc++;
        imem_resp_valid_i = 1'b0;
        imem_resp_inst_i  = '0;
        if (!rst_i && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_resp_valid_i = 1'b1;
            imem_resp_inst_i  = inst_of(pend_q[0].addr);
            void'(pend_q.pop_front());
        end
        if (!rst_i) begin
            chk("outstanding_le_max", (pend_q.size() + int'(imem_resp_valid_i)) <= 2, 1'b1);
        end
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b1;
        repeat (n) step();
        rst_i = 1'b0;
    endtask

    initial begin
        // 1: reset state, zero-wait streaming
        delay = 1; id_ready_i = 1'b1;
        do_reset(2);
        chk("rst_req_valid", s_req_valid, 1'b0);
        chk("rst_if_valid", s_if_valid, 1'b0);
        chk("rst_ifToId", s_data, 64'h0);
        chk("rst_addr", s_addr, 32'h8000_0000);
        step();
        chk("c0_req_valid", s_req_valid, 1'b1);
        chk("c0_addr", s_addr, 32'h8000_0000);
        chk("c0_if_valid", s_if_valid, 1'b0);
        step();
        chk("c1_addr", s_addr, 32'h8000_0004);
        chk("c1_if_valid", s_if_valid, 1'b0);
        step();
        chk("c2_if_valid", s_if_valid, 1'b1);
        chk("c2_data", s_data, {32'h8000_0000, inst_of(32'h8000_0000)});
        p0 = n_pop;
        repeat (8) step();
        chk("stream_rate", n_pop - p0, 8);

        // 2: ID stalled fills the queue with exactly FQ_DEPTH fetches
        id_ready_i = 1'b0;
        do_reset(1);
        f0 = n_fire;
        repeat (10) step();
        chk("stall_fires", n_fire - f0, 4);
        chk("stall_req_valid", s_req_valid, 1'b0);
        chk("stall_if_valid", s_if_valid, 1'b1);
        id_ready_i = 1'b1;
        p0 = n_pop;
        step();
        chk("release_no_req", s_req_valid, 1'b0);
        step();
        chk("release_req", s_req_valid, 1'b1);
        repeat (2) step();
        chk("release_pops", n_pop - p0, 4);
        repeat (10) step();

        // 3: two-cycle response delay caps throughput at 2 per 3 cycles
        delay = 2; id_ready_i = 1'b1;
        do_reset(1);
        f0 = n_fire; p0 = n_pop;
        repeat (33) step();
        chk("lat_fires", n_fire - f0, 22);
        chk("lat_pops", n_pop - p0, 20);

        // 4: flush with two requests in flight and two queued entries
        delay = 3; id_ready_i = 1'b0;
        do_reset(1);
        repeat (6) step();
        chk("pre_flush_valid", s_if_valid, 1'b1);
        flush_i = 1'b1; flush_pc_i = 32'h8000_1000;
        step();
        flush_i = 1'b0; id_ready_i = 1'b1;
        step();
        chk("post_flush_empty", s_if_valid, 1'b0);
        chk("post_flush_no_req", s_req_valid, 1'b0);
        step();
        chk("redirect_req", s_req_valid, 1'b1);
        chk("redirect_addr", s_addr, 32'h8000_1000);
        p0 = n_pop;
        repeat (10) step();
        chk("redirect_pops", n_pop - p0, 4);

        // 5: flush colliding with a response and id_ready, then a second flush
        delay = 3; id_ready_i = 1'b0;
        do_reset(1);
        repeat (7) step();
        flush_i = 1'b1; flush_pc_i = 32'h8000_3000; id_ready_i = 1'b1;
        p0 = n_pop;
        step();
        chk("flush_resp_no_pop", n_pop - p0, 0);
        flush_pc_i = 32'h8000_2000;
        step();
        flush_i = 1'b0;
        step();
        chk("b2b_req", s_req_valid, 1'b1);
        chk("b2b_addr", s_addr, 32'h8000_2000);
        p0 = n_pop;
        repeat (10) step();
        chk("b2b_pops", n_pop - p0, 4);

        // 6: reset in the middle of a stalled, full queue
        delay = 1; id_ready_i = 1'b0;
        do_reset(1);
        repeat (6) step();
        chk("full_req_valid", s_req_valid, 1'b0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        step();
        chk("mid_rst_if_valid", s_if_valid, 1'b0);
        chk("mid_rst_addr", s_addr, 32'h8000_0000);
        chk("mid_rst_req", s_req_valid, 1'b1);
        id_ready_i = 1'b1;
        step();
        chk("mid_rst_c1_valid", s_if_valid, 1'b0);
        step();
        chk("mid_rst_c2_valid", s_if_valid, 1'b1);
        chk("mid_rst_c2_data", s_data, {32'h8000_0000, inst_of(32'h8000_0000)});
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
